asynch_clk_div_8: RTL and testbench
===================================

Name: asynch_clk_div_8

Overview:
- Ripple (asynchronous) binary clock divider. Default divide ratio is 8, giving a 50%-duty output clock.
- Chain of toggle flip-flops: stage 0 is clocked by clk; each later stage is clocked by the previous stage output.
- Used as a low-cost clock source for slow domains where stage-to-stage skew is acceptable.
- Also exposes intermediate taps (÷2, ÷4) and the raw ripple count.

Parameters:
- STAGES, 3, number of toggle stages. Divide ratio is 2^STAGES. Legal range 1..16; default gives ÷8.

Ports:
- clk  input  1  source clock
- rst_n  input  1  asynchronous active-low reset
- out_clk  output  1  divided clock, frequency clk/2^STAGES, 50% duty; equals the last stage
- div2_clk  output  1  stage 0 output, clk/2
- div4_clk  output  1  stage 1 output, clk/4; tied 0 when STAGES<2
- ripple_cnt  output  STAGES  all stage outputs, bit i = stage i

Behaviour:
Reset:
- Asynchronous, active-low. While rst_n=0 every stage clears immediately, independent of clk.
- During reset: out_clk=0, div2_clk=0, div4_clk=0, ripple_cnt=0.
- Reset asserted mid-operation clears all stages at once, even if a ripple is in flight; no partial state is kept.

Stage clocking:
- Stage 0 toggles on every rising edge of clk while rst_n=1.
- Stage i (i≥1) toggles on every falling edge of stage i-1, i.e. rising edge of its inverse. The chain therefore behaves as a binary up-counter.
- ripple_cnt increments by 1 per clk rising edge, wrapping from 2^STAGES-1 to 0. It is valid only after the ripple has settled (STAGES flop delays after the clk edge).

Output timing (STAGES=3, reset released between clk edges):
- 1st clk rising edge after release: ripple_cnt=1, div2_clk=1.
- 4th rising edge: out_clk rises (ripple_cnt=4).
- 8th rising edge: out_clk falls (ripple_cnt=0).
- Thereafter: period 8 clk cycles, high 4, low 4.

Latency and edge alignment:
- Stage i's output edge lags the causing clk rising edge by (i+1) flop clk-to-q delays. No zero-delay alignment to clk is guaranteed.
- Outputs come directly from flops; no combinational gating, so outputs are glitch-free.

Reset release:
- If release coincides with a clk rising edge, that edge may or may not count. Either outcome is legal; outputs must stay glitch-free.

Optional Feature:
- Macro ASYNCH_CLK_DIV_RST_SYNC_EN.
- Defined:
  - rst_n passes through an internal 2-flop synchronizer clocked by clk: asynchronous assert, synchronous deassert.
  - Stages use the synchronized reset.
  - Counting starts on the 3rd clk rising edge after rst_n rises, so out_clk first rises on the 6th rising edge after release (STAGES=3).
  - Assertion is still immediate.
- Undefined: rst_n drives the stage resets directly; timing as stated in Behaviour.

Test Plan:
- Reset hold: rst_n=0 for 5 clk cycles with clk toggling (10 ns period) -> out_clk, div2_clk, div4_clk = 0 and ripple_cnt=0 throughout.
- Release at clk falling edge, STAGES=3 -> div2_clk rises at 1st rising edge; div4_clk at 2nd; out_clk at 4th; out_clk falls at 8th.
- Steady state over 10 output periods -> out_clk period 80 ns, high time 40 ns; div2_clk period 20 ns; div4_clk period 40 ns; ripple_cnt sequence 1,2,…,7,0,1.
- Mid-run reset: assert rst_n=0 when ripple_cnt=5 (out_clk=1), no clk edge -> all outputs 0 immediately. Release -> sequence restarts from count 1.
- STAGES=4 override -> out_clk period 16 clk cycles, high 8; wrap 15→0.
- ASYNCH_CLK_DIV_RST_SYNC_EN defined -> first out_clk rise on 6th clk rising edge after release. Assertion still clears outputs without a clk edge.

Source files
------------

// File: rtl/asynch_clk_div_8.sv
// Ripple (asynchronous) binary clock divider: STAGES toggle flops, each clocked by the previous stage.
// Optional macro ASYNCH_CLK_DIV_RST_SYNC_EN adds a 2-flop reset synchronizer (async assert, sync deassert).
module asynch_clk_div_8 #(
    parameter int unsigned STAGES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              out_clk,
    output logic              div2_clk,
    output logic              div4_clk,
    output logic [STAGES-1:0] ripple_cnt
);

    logic              stage_rst_n;
    logic [STAGES-1:0] stage_w;

`ifdef ASYNCH_CLK_DIV_RST_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    // NOTE: the synchronizer keeps the async clear so assertion still reaches the stages without a clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign stage_rst_n = sync_q[1];
`else
    assign stage_rst_n = rst_n;
`endif

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic tgl_q;
        logic tgl_d;

        always_comb begin
            tgl_d = ~tgl_q;
        end

        if (i == 0) begin : g_first
            // NOTE: non-blocking assignment keeps each flop's update ordered against its own clock edge.
            always_ff @(posedge clk or negedge stage_rst_n) begin
                if (!stage_rst_n) begin
                    tgl_q <= 1'b0;
                end else begin
                    tgl_q <= tgl_d;
                end
            end
        end else begin : g_next
            // Falling edge of the previous stage is the carry of a binary up-counter.
            always_ff @(negedge stage_w[i-1] or negedge stage_rst_n) begin
                if (!stage_rst_n) begin
                    tgl_q <= 1'b0;
                end else begin
                    tgl_q <= tgl_d;
                end
            end
        end

        assign stage_w[i] = tgl_q;
    end

    assign out_clk    = stage_w[STAGES-1];
    assign div2_clk   = stage_w[0];
    assign ripple_cnt = stage_w;

    if (STAGES >= 2) begin : g_div4
        assign div4_clk = stage_w[1];
    end else begin : g_no_div4
        assign div4_clk = 1'b0;
    end

endmodule

// File: tb/tb_asynch_clk_div_8.sv
// Scoreboard bench for asynch_clk_div_8: driver pushes expected counts, monitor samples and compares.
`timescale 1ns/1ps
module tb_asynch_clk_div_8;

`ifdef ASYNCH_CLK_DIV_RST_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    typedef struct {
        string tag;
        int    cnt;
    } sb_item_t;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       sample_req = 1'b0;
    logic       out3, d2_3, d4_3;
    logic [2:0] rc3;
    logic       out4, d2_4, d4_4;
    logic [3:0] rc4;

    sb_item_t sb_q[$];
    int       n_tests = 0;
    int       n_fail  = 0;
    int       m_cnt   = 0;
    int       rel_tbl[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    time      t_rel;
    time      rise3[$], fall3[$], rise2[$], rise_d4[$], rise4[$], fall4[$];

    always #5 clk = ~clk;

    asynch_clk_div_8 #(.STAGES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_clk   (out3),
        .div2_clk  (d2_3),
        .div4_clk  (d4_3),
        .ripple_cnt(rc3)
    );

    asynch_clk_div_8 #(.STAGES(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_clk   (out4),
        .div2_clk  (d2_4),
        .div4_clk  (d4_4),
        .ripple_cnt(rc4)
    );

    always @(posedge out3) rise3.push_back($time);
    always @(negedge out3) fall3.push_back($time);
    always @(posedge d2_3) rise2.push_back($time);
    always @(posedge d4_3) rise_d4.push_back($time);
    always @(posedge out4) rise4.push_back($time);
    always @(negedge out4) fall4.push_back($time);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push(input string tag, input int cnt);
        sb_item_t it;
        it.tag = tag;
        it.cnt = cnt;
        sb_q.push_back(it);
        sample_req = ~sample_req;
    endtask

    task automatic check_period(input string name, input time rq[$], input time exp_per);
        time act;
        act = 0;
        if (rq.size() >= 2) act = rq[rq.size()-1] - rq[rq.size()-2];
        check(name, 64'(act), 64'(exp_per));
    endtask

    task automatic check_high(input string name, input time rq[$], input time fq[$], input time exp_high);
        time act;
        time f;
        act = 0;
        if (fq.size() > 0 && rq.size() > 0) begin
            f = fq[fq.size()-1];
            if (f > rq[rq.size()-1]) act = f - rq[rq.size()-1];
            else if (rq.size() > 1) act = f - rq[rq.size()-2];
        end
        check(name, 64'(act), 64'(exp_high));
    endtask

    task automatic check_first(input string name, input time rq[$], input time exp_delay);
        time act;
        act = 0;
        if (rq.size() > 0) act = rq[0] - t_rel;
        check(name, 64'(act), 64'(exp_delay));
    endtask

    // Release on a clk falling edge, then follow the hand table of counts after the first rising edges.
    task automatic release_and_count(input string tag);
        @(negedge clk);
        rise3.delete();
        fall3.delete();
        rise2.delete();
        rise_d4.delete();
        rise4.delete();
        fall4.delete();
        rst_n = 1'b1;
        t_rel = $time;
        m_cnt = 0;
        for (int k = 1; k <= LAG + 9; k++) begin
            @(negedge clk);
            if (k > LAG) m_cnt = rel_tbl[k-LAG-1];
            push(tag, m_cnt);
        end
        check_first({tag, "_div2_first_rise"}, rise2, time'(LAG * 10 + 5));
        check_first({tag, "_div4_first_rise"}, rise_d4, time'((LAG + 1) * 10 + 5));
        check_first({tag, "_out_first_rise"}, rise3, time'((LAG + 3) * 10 + 5));
    endtask

    // Monitor: samples 1 ns after each stimulus notification and drains the scoreboard.
    initial begin
        sb_item_t   it;
        logic [2:0] e3;
        logic [3:0] e4;
        forever begin
            @(sample_req);
            #1;
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                e3 = 3'(it.cnt);
                e4 = 4'(it.cnt);
                check({it.tag, "_div8"}, 64'({out3, d4_3, d2_3, rc3}), 64'({e3[2], e3[1], e3[0], e3}));
                check({it.tag, "_div16"}, 64'({out4, d4_4, d2_4, rc4}), 64'({e4[3], e4[1], e4[0], e4}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            push("rst_hold", 0);
            @(posedge clk);
            #2 push("rst_hold_hi", 0);
        end

        release_and_count("release");

        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            m_cnt++;
            push("steady", m_cnt);
        end
        check_period("out_clk_period", rise3, 80);
        check_high("out_clk_high", rise3, fall3, 40);
        check_period("div2_period", rise2, 20);
        check_period("div4_period", rise_d4, 40);
        check_period("out16_period", rise4, 160);
        check_high("out16_high", rise4, fall4, 80);

        while (m_cnt % 8 != 5) begin
            @(negedge clk);
            m_cnt++;
            push("to_five", m_cnt);
        end
        #2 rst_n = 1'b0;
        push("mid_rst", 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            push("mid_rst_hold", 0);
        end

        release_and_count("restart");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            m_cnt++;
            push("wrap", m_cnt);
        end

        #3;
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
